// File: rtl/conditioner_pkg.sv
// Shared types and defaults for the dual switch conditioner.
// Optional edge pulses: SWITCH_CONDITIONER_EDGE_PULSE_EN.
package conditioner_pkg;

    typedef enum logic {
        STABLE   = 1'b0,
        COUNTING = 1'b1
    } chan_state_t;

    localparam int DEF_SYNC_STAGES     = 2;
    localparam int DEF_DEBOUNCE_CYCLES = 16;

endpackage

// File: rtl/debounce_channel.sv
// One switch channel: synchronizer, debounce FSM/counter, clean level
// and a registered change flag aligned with the new level.
module debounce_channel
    import conditioner_pkg::*;
#(
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sw_raw,
    output logic level,
    output logic change
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync;
    chan_state_t            state;
    logic [CW-1:0]          cnt;
    logic [CW-1:0]          cnt_inc;

    assign sync    = sync_q[SYNC_STAGES-1];
    assign cnt_inc = cnt + CW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sw_raw};
        end
    end

    // Counter only runs while sync disagrees; it clears before reaching LAST+1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= STABLE;
            cnt    <= '0;
            level  <= 1'b0;
            change <= 1'b0;
        end else begin
            change <= 1'b0;
            unique case (state)
                STABLE: begin
                    cnt <= '0;
                    if (sync != level) begin
                        if (DEBOUNCE_CYCLES == 1) begin
                            level  <= sync;
                            change <= 1'b1;
                        end else begin
                            cnt   <= CW'(1);
                            state <= COUNTING;
                        end
                    end
                end
                COUNTING: begin
                    if (sync == level) begin
                        cnt   <= '0;
                        state <= STABLE;
                    end else if (cnt_inc == LAST) begin
                        level  <= sync;
                        change <= 1'b1;
                        cnt    <= '0;
                        state  <= STABLE;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/dual_switch_conditioner.sv
// Two debounced switch channels feeding the gate block's A/B inputs.
// Define SWITCH_CONDITIONER_EDGE_PULSE_EN to add per-channel edge pulses.
module dual_switch_conditioner
    import conditioner_pkg::*;
#(
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sw_a_raw,
    input  logic sw_b_raw,
    output logic A,
    output logic B,
    output logic any_change
`ifdef SWITCH_CONDITIONER_EDGE_PULSE_EN
    ,
    output logic a_rise,
    output logic a_fall,
    output logic b_rise,
    output logic b_fall
`endif
);

    logic chg_a;
    logic chg_b;

    debounce_channel #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_ch_a (
        .clk   (clk),
        .rst_n (rst_n),
        .sw_raw(sw_a_raw),
        .level (A),
        .change(chg_a)
    );

    debounce_channel #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_ch_b (
        .clk   (clk),
        .rst_n (rst_n),
        .sw_raw(sw_b_raw),
        .level (B),
        .change(chg_b)
    );

    // Both flags are registered, so a simultaneous flip is still one pulse.
    assign any_change = chg_a | chg_b;

`ifdef SWITCH_CONDITIONER_EDGE_PULSE_EN
    assign a_rise = chg_a &  A;
    assign a_fall = chg_a & ~A;
    assign b_rise = chg_b &  B;
    assign b_fall = chg_b & ~B;
`endif

endmodule

// File: tb/tb_dual_switch_conditioner.sv
// Directed bench for dual_switch_conditioner (SYNC_STAGES=2, DEBOUNCE_CYCLES=4).
module tb_dual_switch_conditioner;

    logic clk = 1'b0;
    logic rst_n;
    logic sw_a_raw;
    logic sw_b_raw;
    logic A;
    logic B;
    logic any_change;
`ifdef SWITCH_CONDITIONER_EDGE_PULSE_EN
    logic a_rise, a_fall, b_rise, b_fall;
`endif

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    dual_switch_conditioner #(
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sw_a_raw  (sw_a_raw),
        .sw_b_raw  (sw_b_raw),
        .A         (A),
        .B         (B),
        .any_change(any_change)
`ifdef SWITCH_CONDITIONER_EDGE_PULSE_EN
        ,
        .a_rise    (a_rise),
        .a_fall    (a_fall),
        .b_rise    (b_rise),
        .b_fall    (b_fall)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_count(input int n, output int pulses);
        pulses = 0;
        repeat (n) begin
            tick();
            if (any_change) pulses++;
        end
    endtask

    // Raw inputs were just changed; expect the flip on exactly the 6th edge.
    task automatic flip_window(input string tag, input logic ea, input logic eb,
                               input logic pa, input logic pb);
        int p;
        run_count(5, p);
        check({tag, "_pre_pulses"}, p, 0);
        check({tag, "_pre_A"}, A, pa);
        check({tag, "_pre_B"}, B, pb);
        tick();
        check({tag, "_A"}, A, ea);
        check({tag, "_B"}, B, eb);
        check({tag, "_chg"}, any_change, 1);
`ifdef SWITCH_CONDITIONER_EDGE_PULSE_EN
        check({tag, "_a_rise"}, a_rise, ea & ~pa);
        check({tag, "_a_fall"}, a_fall, ~ea & pa);
        check({tag, "_b_rise"}, b_rise, eb & ~pb);
        check({tag, "_b_fall"}, b_fall, ~eb & pb);
`endif
        tick();
        check({tag, "_chg_end"}, any_change, 0);
`ifdef SWITCH_CONDITIONER_EDGE_PULSE_EN
        check({tag, "_edges_end"},
              {28'd0, a_rise, a_fall, b_rise, b_fall}, 0);
`endif
    endtask

    initial begin
        int p;
        rst_n    = 1'b0;
        sw_a_raw = 1'b1;
        sw_b_raw = 1'b1;
        repeat (3) tick();
        check("rst_A", A, 0);
        check("rst_B", B, 0);
        check("rst_chg", any_change, 0);
`ifdef SWITCH_CONDITIONER_EDGE_PULSE_EN
        check("rst_edges", {28'd0, a_rise, a_fall, b_rise, b_fall}, 0);
`endif

        rst_n = 1'b1;
        flip_window("rst_rel", 1, 1, 0, 0);

        sw_a_raw = 1'b0;
        flip_window("a_fall", 0, 1, 1, 1);

        sw_a_raw = 1'b1;
        repeat (3) tick();
        sw_a_raw = 1'b0;
        run_count(10, p);
        check("glitch_pulses", p, 0);
        check("glitch_A", A, 0);
        check("glitch_state", 32'(dut.u_ch_a.state), 0);
        check("glitch_cnt", 32'(dut.u_ch_a.cnt), 0);

        sw_b_raw = 1'b0;
        flip_window("b_fall", 0, 0, 0, 1);

        p = 0;
        for (int i = 0; i < 10; i++) begin
            sw_b_raw = ~sw_b_raw;
            tick();
            if (any_change) p++;
        end
        check("bounce_pulses", p, 0);
        check("bounce_B", B, 0);
        sw_b_raw = 1'b1;
        flip_window("bounce", 0, 1, 0, 0);

        sw_b_raw = 1'b0;
        flip_window("b_fall2", 0, 0, 0, 1);

        sw_a_raw = 1'b1;
        sw_b_raw = 1'b1;
        flip_window("both", 1, 1, 0, 0);

        sw_a_raw = 1'b0;
        repeat (4) tick();
        check("mid_state", 32'(dut.u_ch_a.state), 1);
        check("mid_cnt", 32'(dut.u_ch_a.cnt), 2);
        check("mid_A_pre", A, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_A", A, 0);
        check("mid_rst_B", B, 0);
        check("mid_rst_cnt", 32'(dut.u_ch_a.cnt), 0);
        sw_b_raw = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        run_count(10, p);
        check("post_rst_pulses", p, 0);
        check("post_rst_A", A, 0);
        check("post_rst_B", B, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
